// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: two buffered result channels, round-robin into one
// register-file write port, with pending-write hazard flags.
module regfile_wb_arbiter #(
  parameter int data_width = 32,
  parameter int addr_width = 8,
  parameter int fifo_depth = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [addr_width-1:0] a_addr,
  input  logic [data_width-1:0] a_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [addr_width-1:0] b_addr,
  input  logic [data_width-1:0] b_data,
  output logic                  we_out,
  output logic [addr_width-1:0] addr_wr_out,
  output logic [data_width-1:0] data_out,
  input  logic [addr_width-1:0] chk_addr_a,
  input  logic [addr_width-1:0] chk_addr_b,
  output logic                  busy_a,
  output logic                  busy_b,
  output logic                  idle
);

  localparam int PW = $clog2(fifo_depth);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [addr_width-1:0] addr;
    logic [data_width-1:0] data;
  } entry_t;

  entry_t          mem_q [2][fifo_depth];
  entry_t          mem_d [2][fifo_depth];
  logic [PW-1:0]   wr_ptr_q [2];
  logic [PW-1:0]   wr_ptr_d [2];
  logic [PW-1:0]   rd_ptr_q [2];
  logic [PW-1:0]   rd_ptr_d [2];
  logic [CW-1:0]   cnt_q [2];
  logic [CW-1:0]   cnt_d [2];
  logic            rr_q, rr_d;
  logic            we_q, we_d;
  logic [addr_width-1:0] addr_q, addr_d;
  logic [data_width-1:0] data_q, data_d;

  entry_t          in_e [2];
  entry_t          head [2];
  logic [1:0]      vld, rdy, push, nempty, grant;
  logic [addr_width-1:0] chk [2];
  logic [1:0]      busy;

  always_comb begin
    in_e[0] = {a_addr, a_data};
    in_e[1] = {b_addr, b_data};
    vld     = {b_valid, a_valid};
    chk[0]  = chk_addr_a;
    chk[1]  = chk_addr_b;
    for (int c = 0; c < 2; c++) begin
      rdy[c]    = !rst && (cnt_q[c] < CW'(fifo_depth));
      push[c]   = vld[c] && rdy[c] && (in_e[c].addr != '0);
      nempty[c] = cnt_q[c] != '0;
      head[c]   = mem_q[c][rd_ptr_q[c]];
    end
  end

  // rr_q == 0 favours A when both heads are present
  always_comb begin
    grant    = '0;
    grant[0] = nempty[0] && (!nempty[1] || !rr_q);
    grant[1] = nempty[1] && !grant[0];
    rr_d     = rr_q;
    if (grant[0]) rr_d = 1'b1;
    if (grant[1]) rr_d = 1'b0;
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    for (int c = 0; c < 2; c++) begin
      if (push[c]) begin
        mem_d[c][wr_ptr_q[c]] = in_e[c];
        wr_ptr_d[c] = wr_ptr_q[c] + 1'b1;
      end
      if (grant[c]) rd_ptr_d[c] = rd_ptr_q[c] + 1'b1;
      cnt_d[c] = cnt_q[c] + CW'(push[c]) - CW'(grant[c]);
    end
  end

  always_comb begin
    we_d   = |grant;
    addr_d = addr_q;
    data_d = data_q;
    unique case (1'b1)
      grant[0]: begin
        addr_d = head[0].addr;
        data_d = head[0].data;
      end
      grant[1]: begin
        addr_d = head[1].addr;
        data_d = head[1].data;
      end
      default: ;
    endcase
  end

  always_comb begin
    busy = '0;
    for (int k = 0; k < 2; k++) begin
      for (int ch = 0; ch < 2; ch++) begin
        for (int i = 0; i < fifo_depth; i++) begin
          if ((CW'(i) < cnt_q[ch]) &&
              (mem_q[ch][rd_ptr_q[ch] + PW'(i)].addr == chk[k]))
            busy[k] = 1'b1;
        end
      end
      if (we_q && (addr_q == chk[k])) busy[k] = 1'b1;
      if (chk[k] == '0) busy[k] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        cnt_q[c]    <= '0;
      end
      rr_q   <= 1'b0;
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      rr_q     <= rr_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  assign a_ready     = rdy[0];
  assign b_ready     = rdy[1];
  assign we_out      = we_q;
  assign addr_wr_out = addr_q;
  assign data_out    = data_q;
  assign busy_a      = busy[0];
  assign busy_b      = busy[1];
  assign idle        = (cnt_q[0] == '0) && (cnt_q[1] == '0) && !we_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: constant vector table, queue-based
// reference model under random traffic, and directed corner sequences.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid;
  logic        a_ready, b_ready;
  logic [7:0]  a_addr, b_addr;
  logic [31:0] a_data, b_data;
  logic        we_out;
  logic [7:0]  addr_wr_out;
  logic [31:0] data_out;
  logic [7:0]  chk_addr_a, chk_addr_b;
  logic        busy_a, busy_b, idle;

  regfile_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready),
    .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready),
    .b_addr(b_addr), .b_data(b_data),
    .we_out(we_out), .addr_wr_out(addr_wr_out),
    .data_out(data_out),
    .chk_addr_a(chk_addr_a), .chk_addr_b(chk_addr_b),
    .busy_a(busy_a), .busy_b(busy_b), .idle(idle)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic cmp(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp,
               $time);
    end
  endtask

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } ent_t;

  ent_t        qa[$], qb[$];
  bit          m_rr_b;
  bit          m_we;
  logic [7:0]  m_addr;
  logic [31:0] m_data;

  function automatic bit m_busy(logic [7:0] c);
    if (c == 0) return 0;
    foreach (qa[i]) if (qa[i].addr == c) return 1;
    foreach (qb[i]) if (qb[i].addr == c) return 1;
    return m_we && (m_addr == c);
  endfunction

  task automatic check_model();
    cmp("a_ready", a_ready, !rst && qa.size() < 4);
    cmp("b_ready", b_ready, !rst && qb.size() < 4);
    cmp("we_out", we_out, m_we);
    cmp("addr_wr_out", addr_wr_out, m_addr);
    cmp("data_out", data_out, m_data);
    cmp("busy_a", busy_a, m_busy(chk_addr_a));
    cmp("busy_b", busy_b, m_busy(chk_addr_b));
    cmp("idle", idle, qa.size() == 0 && qb.size() == 0 && !m_we);
  endtask

  task automatic tick();
    bit   acc_a, acc_b;
    ent_t e;
    @(posedge clk);
    acc_a = a_valid && !rst && qa.size() < 4 && a_addr != 0;
    acc_b = b_valid && !rst && qb.size() < 4 && b_addr != 0;
    if (rst) begin
      qa.delete();
      qb.delete();
      m_rr_b = 0;
      m_we   = 0;
      m_addr = 0;
      m_data = 0;
    end else begin
      m_we = 0;
      if (qa.size() != 0 && (qb.size() == 0 || !m_rr_b)) begin
        e = qa.pop_front();
        m_we = 1; m_addr = e.addr; m_data = e.data; m_rr_b = 1;
      end else if (qb.size() != 0) begin
        e = qb.pop_front();
        m_we = 1; m_addr = e.addr; m_data = e.data; m_rr_b = 0;
      end
      if (acc_a) qa.push_back({a_addr, a_data});
      if (acc_b) qb.push_back({b_addr, b_data});
    end
    #1;
  endtask

  task automatic drive(bit r, bit av, logic [7:0] aa, logic [31:0] ad,
                       bit bv, logic [7:0] ba, logic [31:0] bd);
    rst = r;
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  typedef struct {
    bit rst;
    bit av; logic [7:0] aa; logic [31:0] ad;
    bit bv; logic [7:0] ba; logic [31:0] bd;
    bit we; logic [7:0] wa; logic [31:0] wd;
    bit idle; bit ar; bit br;
  } vec_t;

  vec_t tv[$];

  initial begin
    ent_t got_a[$], got_b[$];
    int   ia, ib, stalls;
    bit   exp_ba[4];

    chk_addr_a = 0;
    chk_addr_b = 0;
    drive(1, 0, 0, 0, 0, 0, 0);
    tick();
    tick();

    tv.push_back('{1, 0,0,0, 0,0,0, 0,8'h00,32'h0, 1,0,0});
    tv.push_back('{0, 1,5,32'hDEADBEEF, 0,0,0, 0,8'h00,32'h0, 1,1,1});
    tv.push_back('{0, 0,0,0, 0,0,0, 0,8'h00,32'h0, 0,1,1});
    tv.push_back('{0, 0,0,0, 0,0,0, 1,8'h05,32'hDEADBEEF, 0,1,1});
    tv.push_back('{0, 0,0,0, 0,0,0, 0,8'h05,32'hDEADBEEF, 1,1,1});
    tv.push_back('{1, 0,0,0, 0,0,0, 0,8'h05,32'hDEADBEEF, 1,0,0});
    tv.push_back('{0, 1,1,32'h11, 1,9,32'h99, 0,8'h00,32'h0, 1,1,1});
    tv.push_back('{0, 1,2,32'h22, 1,10,32'hAA, 0,8'h00,32'h0, 0,1,1});
    tv.push_back('{0, 1,3,32'h33, 1,11,32'hBB, 1,8'h01,32'h11, 0,1,1});
    tv.push_back('{0, 0,0,0, 0,0,0, 1,8'h09,32'h99, 0,1,1});
    tv.push_back('{0, 0,0,0, 0,0,0, 1,8'h02,32'h22, 0,1,1});
    tv.push_back('{0, 0,0,0, 0,0,0, 1,8'h0A,32'hAA, 0,1,1});
    tv.push_back('{0, 0,0,0, 0,0,0, 1,8'h03,32'h33, 0,1,1});
    tv.push_back('{0, 0,0,0, 0,0,0, 1,8'h0B,32'hBB, 0,1,1});
    tv.push_back('{0, 0,0,0, 0,0,0, 0,8'h0B,32'hBB, 1,1,1});
    tv.push_back('{0, 1,0,32'h1234, 0,0,0, 0,8'h0B,32'hBB, 1,1,1});
    tv.push_back('{0, 0,0,0, 0,0,0, 0,8'h0B,32'hBB, 1,1,1});
    tv.push_back('{0, 0,0,0, 0,0,0, 0,8'h0B,32'hBB, 1,1,1});

    foreach (tv[i]) begin
      drive(tv[i].rst, tv[i].av, tv[i].aa, tv[i].ad,
            tv[i].bv, tv[i].ba, tv[i].bd);
      @(negedge clk);
      cmp($sformatf("vec%0d.we", i), we_out, tv[i].we);
      cmp($sformatf("vec%0d.addr", i), addr_wr_out, tv[i].wa);
      cmp($sformatf("vec%0d.data", i), data_out, tv[i].wd);
      cmp($sformatf("vec%0d.idle", i), idle, tv[i].idle);
      cmp($sformatf("vec%0d.a_ready", i), a_ready, tv[i].ar);
      cmp($sformatf("vec%0d.b_ready", i), b_ready, tv[i].br);
      tick();
    end

    // random traffic against the queue model
    do_reset();
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 59) == 0,
            1'($urandom), 8'($urandom_range(0, 7)), $urandom,
            1'($urandom), 8'($urandom_range(0, 7)), $urandom);
      chk_addr_a = 8'($urandom_range(0, 7));
      chk_addr_b = 8'($urandom_range(0, 7));
      @(negedge clk);
      check_model();
      tick();
    end

    // hazard flag lifetime for a single write to r7
    do_reset();
    chk_addr_a = 7;
    chk_addr_b = 0;
    exp_ba = '{0, 1, 1, 0};
    for (int c = 0; c < 4; c++) begin
      if (c == 0) drive(0, 1, 7, 32'hCAFE, 0, 0, 0);
      else        drive(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      cmp($sformatf("busy_a.c%0d", c), busy_a, exp_ba[c]);
      cmp($sformatf("busy_b.c%0d", c), busy_b, 0);
      check_model();
      tick();
    end

    // both channels stream 8 entries; FIFOs fill and producers hold
    do_reset();
    chk_addr_a = 0;
    ia = 0; ib = 0; stalls = 0;
    for (int c = 0; c < 60; c++) begin
      drive(0, ia < 8, 8'(20 + ia), 32'(32'hA00 + ia),
               ib < 8, 8'(40 + ib), 32'(32'hB00 + ib));
      @(negedge clk);
      check_model();
      if (b_valid && !b_ready) stalls++;
      if (we_out && addr_wr_out >= 40) got_b.push_back({addr_wr_out, data_out});
      else if (we_out) got_a.push_back({addr_wr_out, data_out});
      if (a_valid && a_ready) ia++;
      if (b_valid && b_ready) ib++;
      tick();
    end
    cmp("b_stall_seen", stalls != 0, 1);
    cmp("a_count", got_a.size(), 8);
    cmp("b_count", got_b.size(), 8);
    foreach (got_a[i])
      cmp($sformatf("a_order%0d", i), got_a[i],
          {8'(20 + i), 32'(32'hA00 + i)});
    foreach (got_b[i])
      cmp($sformatf("b_order%0d", i), got_b[i],
          {8'(40 + i), 32'(32'hB00 + i)});

    // reset with both FIFOs loaded drops everything
    do_reset();
    for (int c = 0; c < 6; c++) begin
      drive(0, 1, 8'(50 + c), 32'(c), 1, 8'(60 + c), 32'(c));
      @(negedge clk);
      check_model();
      tick();
    end
    rst = 1;
    @(negedge clk);
    cmp("rst.a_ready", a_ready, 0);
    cmp("rst.b_ready", b_ready, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      cmp($sformatf("post_rst.we%0d", c), we_out, 0);
      cmp($sformatf("post_rst.idle%0d", c), idle, 1);
      check_model();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Writeback arbiter sitting directly upstream of the two-read/one-effective-write register file. Buffers results from two producers (channel A: ALU, channel B: load unit) in per-channel FIFOs and drives exactly one register-file write per cycle, round-robin between channels. Provides combinational pending-write flags so the read stage can stall on RAW hazards. Writes to register 0 are discarded because register 0 reads as zero.

## Interface
- data_width, 32, result width
- addr_width, 8, register address width
- fifo_depth, 4, entries per channel FIFO; power of two, ≥2
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- a_valid / b_valid  in  1  producer has a result
- a_ready / b_ready  out  1  channel can accept this cycle
- a_addr / b_addr  in  addr_width  destination register
- a_data / b_data  in  data_width  result value
- we_out  out  1  register-file write enable
- addr_wr_out  out  addr_width  register-file write address
- data_out  out  data_width  register-file write data
- chk_addr_a / chk_addr_b  in  addr_width  read-stage source addresses to check
- busy_a / busy_b  out  1  write pending to chk_addr_a / chk_addr_b
- idle  out  1  nothing buffered or in flight

## Operation
- Reset: both FIFOs empty, pointers 0, round-robin pointer = A, we_out=0, addr_wr_out=0, data_out=0; a_ready=b_ready=0 while rst high.
- Ready: x_ready = !rst && (count_x < fifo_depth), based on count before this cycle's pop; no pass-through when full.
- Accept: x_valid && x_ready. If x_addr==0: handshake completes, nothing enqueued. Otherwise {addr,data} pushed at the edge.
- Push and pop on same FIFO in one cycle: count unchanged, both take effect.
- Arbitration each cycle over FIFO heads: neither non-empty → no grant; one non-empty → grant it; both → grant round-robin pointer. After any grant, pointer = the other channel. No grant → pointer unchanged.
- Grant pops the head and registers it: we_out←1, addr_wr_out←head addr, data_out←head data. No grant: we_out←0, addr/data hold.
- Ordering: FIFO order preserved within a channel. Cross-channel order to the same register is not guaranteed; upstream uses busy_* to avoid it.
- busy_x (combinational) = chk_addr_x≠0 && (any valid entry in either FIFO has addr==chk_addr_x, or (we_out && addr_wr_out==chk_addr_x)).
- idle = both FIFOs empty && !we_out.

## Timing
- Accept in cycle N → earliest we_out high in cycle N+2 (enqueue at end of N, grant in N+1, registered output in N+2). Register file commits at the end of N+2; a read issued in N+3 returns the new value.
- Throughput: one write per cycle sustained; with both channels continuously non-empty, grants alternate A,B,A,B.
- busy_x deasserts in the cycle after the last matching we_out cycle.
- rst mid-operation: all buffered entries dropped, we_out low the cycle after rst sampled high; no partial writes.
- Full FIFO with valid held: ready low; producer holds; ready reasserts the cycle after a pop of that channel.

## Test plan
- Single A write addr=5 data=0xDEADBEEF accepted cycle 0 → we_out=1, addr_wr_out=5, data_out=0xDEADBEEF in cycle 2 only; idle=1 from cycle 3.
- A and B each push 3 entries (A: regs 1,2,3; B: 9,10,11) simultaneously from reset → write order 1,9,2,10,3,11, one per cycle, no gaps.
- Write to addr 0 with data 0x1234 on A → a_ready high, handshake completes, we_out never asserted, idle stays 1.
- B pushes 5 entries back-to-back with fifo_depth=4 and no drain blocked (A idle) → b_ready stays high as grants drain; force stall scenario by checking ready=0 when count=4, reasserted the cycle after a pop; all 5 written in order.
- Push A addr=7, chk_addr_a=7 → busy_a=1 from cycle 1 through cycle 2 (we_out cycle), 0 in cycle 3; chk_addr_b=0 → busy_b=0 throughout.
- Fill both FIFOs, assert rst one cycle → next cycle we_out=0, idle=1, ready=0 during rst, no further writes after release.
